// File: rtl/alu36_decode.sv
// alu36_decode: single-entry decode/issue buffer with a 32x32 register file and busy scoreboard.
// Optional macro ALU36_DEC_BYPASS_EN: a same-cycle writeback clears hazards and forwards wb_data.
module alu36_decode (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        enable_ex,
    output logic [6:0]  control_out,
    output logic [31:0] src1,
    output logic [31:0] src2,
    output logic [31:0] imm,
    output logic        hazard_stall
);

    typedef enum logic {S_EMPTY, S_HELD} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] busy_q, busy_d;
    logic [31:0] rf_q [32];
    logic        en_q;
    logic [6:0]  ctl_q;
    logic [31:0] s1_q, s2_q, imm_q;

    logic        immp;
    logic [2:0]  opsel;
    logic [4:0]  rd, rs1, rs2;
    logic        rs2_used, rd_wr;
    logic [31:0] wb_clr, busy_eff, rd1, rd2, imm_ext;
    logic        held, hazard, issue, accept;

    assign immp     = hold_q[31];
    assign opsel    = hold_q[30:28];
    assign rd       = hold_q[24:20];
    assign rs1      = hold_q[19:15];
    assign rs2      = hold_q[14:10];
    assign imm_ext  = {{17{hold_q[14]}}, hold_q[14:0]};
    assign rs2_used = !immp || (opsel == 3'b100);
    assign rd_wr    = (opsel != 3'b100) && (rd != 5'd0);

    always_comb begin
        wb_clr = '0;
        if (wb_en) wb_clr[wb_addr] = 1'b1;
    end

`ifdef ALU36_DEC_BYPASS_EN
    assign busy_eff = busy_q & ~wb_clr;
`else
    assign busy_eff = busy_q;
`endif

    assign held   = (state_q == S_HELD);
    assign hazard = held && (busy_eff[rs1] || (rs2_used && busy_eff[rs2]) || (rd_wr && busy_eff[rd]));
    assign issue  = held && !hazard;

    // Ready is masked by reset so fetch never sees a handshake while the block is cleared.
    assign instr_ready  = RESET && (!held || issue);
    assign accept       = instr_valid && instr_ready;
    assign hazard_stall = hazard;

    always_comb begin
        rd1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        rd2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef ALU36_DEC_BYPASS_EN
        if (wb_en && (wb_addr == rs1) && (rs1 != 5'd0)) rd1 = wb_data;
        if (wb_en && (wb_addr == rs2) && (rs2 != 5'd0)) rd2 = wb_data;
`endif
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_HELD;
                    hold_d  = instr;
                end
            end
            S_HELD: begin
                if (issue) begin
                    if (accept) hold_d = instr;
                    else        state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Set beats clear when an issue and a writeback target the same register.
    always_comb begin
        busy_d = busy_q & ~wb_clr;
        if (issue && rd_wr) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_EMPTY;
            hold_q  <= '0;
            busy_q  <= '0;
            en_q    <= 1'b0;
            ctl_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            imm_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            en_q    <= issue;
            if (issue) begin
                ctl_q <= hold_q[31:25];
                s1_q  <= rd1;
                s2_q  <= rd2;
                imm_q <= imm_ext;
            end
            if (wb_en && (wb_addr != 5'd0)) rf_q[wb_addr] <= wb_data;
        end
    end

    assign enable_ex   = en_q;
    assign control_out = ctl_q;
    assign src1        = s1_q;
    assign src2        = s2_q;
    assign imm         = imm_q;

endmodule

// File: tb/tb_alu36_decode.sv
// Scoreboard bench for alu36_decode: program-order register model predicts every issue.
module tb_alu36_decode;

    logic        CLOCK, RESET, instr_valid, instr_ready, wb_en, enable_ex, hazard_stall;
    logic [31:0] instr, wb_data, src1, src2, imm;
    logic [4:0]  wb_addr;
    logic [6:0]  control_out;

    alu36_decode dut (
        .CLOCK(CLOCK), .RESET(RESET), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .enable_ex(enable_ex), .control_out(control_out), .src1(src1), .src2(src2),
        .imm(imm), .hazard_stall(hazard_stall)
    );

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] s1, s2, imm;
        logic        use2;
    } exp_t;

    typedef struct {
        int          seq;
        logic [4:0]  rd;
        logic [31:0] v;
    } wb_t;

`ifdef ALU36_DEC_BYPASS_EN
    localparam int RAW_DELTA = 0;
`else
    localparam int RAW_DELTA = 1;
`endif

    exp_t        exp_q[$];
    wb_t         wbq[$];
    int          iss_q[$];
    logic [31:0] mrf [32];
    int          checks = 0, errors = 0;
    int          cyc = 0, issued_cnt = 0, sent_cnt = 0, last_wb_cyc = 0;
    int          wb_fixed = -1;
    bit          wb_auto = 1;

    initial begin
        CLOCK = 0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial forever begin
        @(posedge CLOCK);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    // Monitor: every issue pops the oldest predicted instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK);
            if (RESET && enable_ex) begin
                issued_cnt++;
                iss_q.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("control", {25'd0, control_out}, {25'd0, e.ctl});
                    chk("src1", src1, e.s1);
                    if (e.use2) chk("src2", src2, e.s2);
                    chk("imm", imm, e.imm);
                end
            end
        end
    end

    // Writeback driver: returns results of issued writers in program order after a delay.
    initial begin
        int cnt = -1;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        forever begin
            @(posedge CLOCK);
            #1;
            wb_en = 0;
            if (RESET && wb_auto && wbq.size() > 0 && wbq[0].seq < issued_cnt) begin
                if (cnt < 0) cnt = (wb_fixed >= 0) ? wb_fixed : int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    wb_en = 1; wb_addr = wbq[0].rd; wb_data = wbq[0].v;
                    void'(wbq.pop_front());
                    last_wb_cyc = cyc + 1;
                    cnt = -1;
                end else cnt--;
            end
        end
    end

    function automatic logic [31:0] enc(input logic ip, input logic [2:0] os, input logic [2:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [14:0] lo);
        return {ip, os, op, rd, rs1, lo};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [2:0] os;
        case ($urandom_range(0, 3))
            0: os = 3'b000;
            1: os = 3'b001;
            2: os = 3'b101;
            default: os = 3'b100;
        endcase
        return enc(1'($urandom), os, 3'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   {5'($urandom_range(0, 7)), 10'($urandom)});
    endfunction

    task automatic send(input logic [31:0] w, input logic [31:0] v, output int acc);
        exp_t e;
        int n = 0;
        instr_valid = 1; instr = w;
        @(negedge CLOCK);
        while (!instr_ready && n < 300) begin
            @(negedge CLOCK);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            instr_valid = 0; acc = -1;
            return;
        end
        @(posedge CLOCK);
        #1;
        acc = cyc;
        instr_valid = 0;
        e.ctl  = w[31:25];
        e.s1   = mrf[w[19:15]];
        e.s2   = mrf[w[14:10]];
        e.use2 = !w[31] || (w[30:28] == 3'b100);
        e.imm  = {{17{w[14]}}, w[14:0]};
        exp_q.push_back(e);
        if (w[30:28] != 3'b100 && w[24:20] != 5'd0) begin
            mrf[w[24:20]] = v;
            wbq.push_back('{seq: sent_cnt, rd: w[24:20], v: v});
        end
        sent_cnt++;
    endtask

    task automatic wait_issue(output int c);
        int n = 0;
        while (iss_q.size() == 0 && n < 300) begin
            @(posedge CLOCK);
            n++;
        end
        if (iss_q.size() == 0) begin
            chk("issue_timeout", 32'd0, 32'd1);
            c = -1000;
        end else c = iss_q.pop_front();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wbq.size() != 0) && n < 2000) begin
            @(posedge CLOCK);
            n++;
        end
        if (exp_q.size() != 0 || wbq.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge CLOCK);
        #1;
        iss_q.delete();
    endtask

    initial begin
        int a0, a1, c0, c1, n0;
        RESET = 0; instr_valid = 0; instr = 0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge CLOCK);
            chk("rst_ready", {31'd0, instr_ready}, 32'd0);
            chk("rst_outs", {enable_ex, hazard_stall, control_out} | src1 | src2 | imm, 32'd0);
        end
        @(posedge CLOCK);
        #1 RESET = 1;
        @(negedge CLOCK);
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        @(posedge CLOCK);
        #1;

        // Back-to-back independent arith instructions
        send(enc(1, 3'b001, 3'b000, 5'd1, 5'd0, 15'd5), $urandom, a0);
        send(enc(1, 3'b001, 3'b000, 5'd2, 5'd0, 15'h7FFD), $urandom, a1);
        wait_issue(c0); wait_issue(c1);
        chk("b2b_first", 32'(c0 - a0), 32'd1);
        chk("b2b_second", 32'(c1 - c0), 32'd1);
        drain();

        // RAW hazard resolved by writeback of 0x1234
        wb_fixed = 3;
        send(enc(1, 3'b001, 3'b000, 5'd3, 5'd0, 15'd1), 32'h1234, a0);
        send(enc(1, 3'b001, 3'b001, 5'd4, 5'd3, 15'd0), $urandom, a1);
        @(negedge CLOCK);
        chk("raw_stall", {31'd0, hazard_stall}, 32'd1);
        wait_issue(c0); wait_issue(c1);
        chk("raw_writer_issue", 32'(c0 - a0), 32'd1);
        chk("raw_reader_vs_wb", 32'(c1 - last_wb_cyc), 32'(RAW_DELTA));
        wb_fixed = -1;
        drain();

        // Store reads rs2 and sets no busy bit
        send(enc(1, 3'b001, 3'b000, 5'd2, 5'd0, 15'd0), 32'h0000DEAD, a0);
        drain();
        send(enc(1, 3'b100, 3'b000, 5'd7, 5'd0, {5'd2, 10'd0}), $urandom, a0);
        send(enc(0, 3'b001, 3'b000, 5'd8, 5'd7, {5'd2, 10'd0}), $urandom, a1);
        wait_issue(c0); wait_issue(c1);
        chk("store_issue", 32'(c0 - a0), 32'd1);
        chk("after_store_nostall", 32'(c1 - a1), 32'd1);
        drain();

        // Writes to r0 are dropped; rd=0 never blocks
        wbq.push_back('{seq: 0, rd: 5'd0, v: 32'h0000FFFF});
        drain();
        send(enc(1, 3'b001, 3'b000, 5'd0, 5'd0, 15'd9), $urandom, a0);
        send(enc(0, 3'b001, 3'b010, 5'd0, 5'd0, 15'd0), $urandom, a1);
        wait_issue(c0); wait_issue(c1);
        chk("r0_first", 32'(c0 - a0), 32'd1);
        chk("r0_nostall", 32'(c1 - a1), 32'd1);
        drain();

        // Reset while a hazard is held
        wb_auto = 0;
        send(enc(1, 3'b001, 3'b000, 5'd5, 5'd0, 15'd3), $urandom, a0);
        send(enc(1, 3'b101, 3'b000, 5'd6, 5'd5, 15'd4), $urandom, a1);
        repeat (3) @(negedge CLOCK);
        chk("mr_stall", {31'd0, hazard_stall}, 32'd1);
        n0 = issued_cnt;
        @(posedge CLOCK);
        #1 RESET = 0;
        #1;
        chk("mr_rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("mr_rst_outs", {30'd0, enable_ex, hazard_stall}, 32'd0);
        exp_q.delete(); wbq.delete(); iss_q.delete();
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        sent_cnt = issued_cnt;
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1;
        wb_auto = 1;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("mr_no_issue", 32'(issued_cnt), 32'(n0));
        send(enc(1, 3'b001, 3'b000, 5'd6, 5'd5, 15'd4), $urandom, a0);
        wait_issue(c0);
        chk("mr_post_issue", 32'(c0 - a0), 32'd1);
        drain();

        // Randomized traffic with random writeback latency
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge CLOCK);
            #1;
            send(rnd_instr(), $urandom, a0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
